// File: rtl/xm_memory_responder.sv
// xm_memory_responder: memory-side responder for the X-Makina datapath memory interface.
// Services one word-addressed read/write at a time from an internal RAM after
// WAIT_STATES wait cycles, answering with a one-cycle ack_o, or with a one-cycle
// err_o for illegal requests. Optional feature macro: XM_MEM_ERR_CAPTURE_EN adds
// errAdr_o/errWr_o, which hold the address and direction of the last rejected request.
module xm_memory_responder #(
    parameter int WORD        = 16,
    parameter int ADDR_W      = 15,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
`ifdef XM_MEM_ERR_CAPTURE_EN
    output logic [ADDR_W-1:0] errAdr_o,
    output logic              errWr_o,
`endif
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [1:0]        datSel_i,
    input  logic              badMem_i,
    input  logic [WORD-1:0]   dat_i,
    output logic [WORD-1:0]   dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [3:0] LAST_WAIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic              enter_resp, enter_err, illegal;
    logic              lat_wr;
    logic [IDX_W-1:0]  lat_idx;
    logic [1:0]        lat_sel;
    logic [WORD-1:0]   lat_dat;
    logic              eff_wr;
    logic [IDX_W-1:0]  eff_idx;
    logic [1:0]        eff_sel;
    logic [WORD-1:0]   eff_dat;
    logic [WORD-1:0]   ram [MEM_WORDS];

    // Shape a RAM word into read data according to the byte-lane select.
    function automatic logic [WORD-1:0] fmt_read(input logic [WORD-1:0] word, input logic [1:0] sel);
        logic [WORD-1:0] res;
        case (sel)
            2'b01:   res = {{(WORD-8){1'b0}}, word[7:0]};
            2'b10:   res = {{(WORD-8){1'b0}}, word[15:8]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Request classification and the request fields in effect (live inputs in IDLE, latched copy otherwise).
    always_comb begin
        illegal = badMem_i | (datSel_i == 2'b00) | ({1'b0, adr_i} >= MEM_LIMIT);
        if (state == S_IDLE) begin
            eff_wr  = wr_i;
            eff_idx = adr_i[IDX_W-1:0];
            eff_sel = datSel_i;
            eff_dat = dat_i;
        end else begin
            eff_wr  = lat_wr;
            eff_idx = lat_idx;
            eff_sel = lat_sel;
            eff_dat = lat_dat;
        end
    end

    // Next-state logic; enter_resp marks the edge that commits writes and raises ack.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        enter_resp   = 1'b0;
        enter_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_i) begin
                    if (illegal) begin
                        state_nxt = S_ERR;
                        enter_err = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = 4'd0;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    state_nxt    = S_RESP;
                    enter_resp   = 1'b1;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            S_RESP, S_ERR: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = 4'd0;
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State register and registered handshake/read-data outputs.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            busy_o   <= 1'b0;
            dat_o    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            ack_o    <= enter_resp;
            err_o    <= enter_err;
            busy_o   <= (state_nxt != S_IDLE);
            if (enter_resp && !eff_wr) begin
                dat_o <= fmt_read(ram[eff_idx], eff_sel);
            end else begin
                dat_o <= dat_o;
            end
        end
    end

    // Capture the accepted request so it survives the wait states.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            lat_wr  <= 1'b0;
            lat_idx <= '0;
            lat_sel <= 2'b00;
            lat_dat <= '0;
        end else if (state == S_IDLE && req_i) begin
            lat_wr  <= wr_i;
            lat_idx <= adr_i[IDX_W-1:0];
            lat_sel <= datSel_i;
            lat_dat <= dat_i;
        end else begin
            lat_wr  <= lat_wr;
            lat_idx <= lat_idx;
            lat_sel <= lat_sel;
            lat_dat <= lat_dat;
        end
    end

    // RAM write port; a reset on the commit edge aborts the write.
    always_ff @(posedge clk_i) begin
        if (!arst_i && enter_resp && eff_wr) begin
            case (eff_sel)
                2'b11:   ram[eff_idx]       <= eff_dat;
                2'b01:   ram[eff_idx][7:0]  <= eff_dat[7:0];
                2'b10:   ram[eff_idx][15:8] <= eff_dat[7:0];
                default: ram[eff_idx]       <= ram[eff_idx];
            endcase
        end
    end

`ifdef XM_MEM_ERR_CAPTURE_EN
    // Record address and direction of each rejected request.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            errAdr_o <= '0;
            errWr_o  <= 1'b0;
        end else if (enter_err) begin
            errAdr_o <= adr_i;
            errWr_o  <= wr_i;
        end else begin
            errAdr_o <= errAdr_o;
            errWr_o  <= errWr_o;
        end
    end
`endif

endmodule
